// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between in-order writeback (A) and a
// long-latency unit (B), with a per-register scoreboard of B-owed destinations.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  claim_en,
    input  logic [ADDR_WIDTH-1:0] claim_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  claim_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] w_in
);

    localparam int         NREG       = 1 << ADDR_WIDTH;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic                  grant_a;
    logic                  grant_b;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  clr_en;

    logic [3:0]            starve_q, starve_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] w_in_q, w_in_d;
    logic                  out_is_b_q, out_is_b_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  claim_err_q, claim_err_d;

    // A wins ties unless B has already waited MAX_WAIT cycles.
    always_comb begin
        grant_b    = b_valid & (~a_valid | (starve_q == MAX_WAIT_C));
        grant_a    = a_valid & ~grant_b;
        grant_any  = grant_a | grant_b;
        grant_addr = grant_b ? b_addr : a_addr;
        grant_data = grant_b ? b_data : a_data;
    end

    always_comb begin
        starve_d = '0;
        if (b_valid && !grant_b) begin
            starve_d = (starve_q == MAX_WAIT_C) ? starve_q : starve_q + 4'd1;
        end
    end

    // Writes to register 0 are consumed but never reach the register file.
    always_comb begin
        w_en_d     = grant_any & (grant_addr != '0);
        rd_addr_d  = grant_any ? grant_addr : rd_addr_q;
        w_in_d     = grant_any ? grant_data : w_in_q;
        out_is_b_d = grant_b;
    end

    // Clear happens as the register file commits the B write; a same-edge
    // claim of that register re-sets the bit and is not a double claim.
    always_comb begin
        clr_en      = w_en_q & out_is_b_q;
        busy_d      = busy_q;
        claim_err_d = claim_err_q;
        if (clr_en) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (claim_en && (claim_addr != '0)) begin
            if (busy_q[claim_addr] && !(clr_en && (rd_addr_q == claim_addr))) begin
                claim_err_d = 1'b1;
            end
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            w_en_q      <= 1'b0;
            rd_addr_q   <= '0;
            w_in_q      <= '0;
            out_is_b_q  <= 1'b0;
            busy_q      <= '0;
            claim_err_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            w_en_q      <= w_en_d;
            rd_addr_q   <= rd_addr_d;
            w_in_q      <= w_in_d;
            out_is_b_q  <= out_is_b_d;
            busy_q      <= busy_d;
            claim_err_q <= claim_err_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign rs1_busy  = busy_q[rs1_addr];
    assign rs2_busy  = busy_q[rs2_addr];
    assign claim_err = claim_err_q;
    assign w_en      = w_en_q;
    assign rd_addr   = rd_addr_q;
    assign w_in      = w_in_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: hand-derived vector table, async-reset sequence,
// then constrained-random traffic against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_addr, b_addr, claim_addr, rs1_addr, rs2_addr, rd_addr;
    logic [DW-1:0] a_data, b_data, w_in;
    logic          claim_en, rs1_busy, rs2_busy, claim_err, w_en;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .claim_en  (claim_en),
        .claim_addr(claim_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .claim_err (claim_err),
        .w_en      (w_en),
        .rd_addr   (rd_addr),
        .w_in      (w_in)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_starve;
    bit   [31:0] m_busy;
    bit          m_wen, m_isb, m_err;
    int          m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        m_starve = 0;
        m_busy   = '0;
        m_wen    = 1'b0;
        m_isb    = 1'b0;
        m_err    = 1'b0;
        m_addr   = 0;
        m_data   = '0;
    endtask

    // Called at posedge+1 with inputs already driven; ends at next posedge+1.
    task automatic model_cycle(output bit ga, output bit gb);
        int clr;
        int ca;
        gb = b_valid && (!a_valid || m_starve == MW);
        ga = a_valid && !gb;
        #2;
        chk("a_ready",  32'(a_ready),  32'(ga));
        chk("b_ready",  32'(b_ready),  32'(gb));
        chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1_addr]));
        chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2_addr]));
        @(posedge clk);
        clr = (m_wen && m_isb) ? m_addr : -1;
        ca  = int'(claim_addr);
        if (clr > 0) m_busy[clr] = 1'b0;
        if (claim_en && ca != 0) begin
            if (m_busy[ca] && ca != clr) m_err = 1'b1;
            m_busy[ca] = 1'b1;
        end
        if (b_valid && !gb) m_starve = (m_starve + 1 > MW) ? MW : m_starve + 1;
        else                m_starve = 0;
        if (ga || gb) begin
            m_addr = ga ? int'(a_addr) : int'(b_addr);
            m_data = ga ? a_data : b_data;
            m_wen  = (m_addr != 0);
            m_isb  = gb;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        chk("w_en",      32'(w_en),      32'(m_wen));
        chk("claim_err", 32'(claim_err), 32'(m_err));
        if (m_wen) begin
            chk("rd_addr", 32'(rd_addr), 32'(m_addr));
            chk("w_in",    w_in,         m_data);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        claim_en = 1'b0; claim_addr = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rs1_addr = 5'd7;
        rs2_addr = 5'd9;
        #1;
        chk("rst_w_en",      32'(w_en),      32'd0);
        chk("rst_claim_err", 32'(claim_err), 32'd0);
        chk("rst_rs1_busy",  32'(rs1_busy),  32'd0);
        chk("rst_rs2_busy",  32'(rs2_busy),  32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- hand-derived vector table ----------------
    typedef struct {
        logic          av;  logic [AW-1:0] aa; logic [DW-1:0] ad;
        logic          bv;  logic [AW-1:0] ba; logic [DW-1:0] bd;
        logic          ce;  logic [AW-1:0] ca;
        logic [AW-1:0] r1;  logic [AW-1:0] r2;
        logic          xar, xbr, xr1, xr2, xwe;
        logic [AW-1:0] xrd; logic [DW-1:0] xwi;
        logic          xerr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic ce, input logic [AW-1:0] ca,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic xar, input logic xbr, input logic xr1, input logic xr2,
                       input logic xwe, input logic [AW-1:0] xrd, input logic [DW-1:0] xwi,
                       input logic xerr);
        vec_t v;
        v = '{av, aa, ad, bv, ba, bd, ce, ca, r1, r2, xar, xbr, xr1, xr2, xwe, xrd, xwi, xerr};
        tbl.push_back(v);
    endtask

    initial begin
        bit ga, gb, hold_a, hold_b;
        logic [AW-1:0] last_claim;

        rst = 1'b1;
        idle_inputs();
        do_reset();

        //   av aa ad            bv ba bd     ce ca  r1 r2   ar br b1 b2  we rd wi            err
        add(0, 0, 0,            0, 0, 0,     0, 0,  7, 0,   0, 0, 0, 0,  0, 0, 0,            0);
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,  7, 0,   1, 0, 0, 0,  1, 5, 32'hDEADBEEF, 0);
        add(0, 0, 0,            0, 0, 0,     0, 0,  7, 0,   0, 0, 0, 0,  0, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,     1, 7,  7, 0,   0, 0, 0, 0,  0, 0, 0,            0);
        add(1, 1, 32'h11,       1, 7, 32'h77, 0, 0, 7, 0,   1, 0, 1, 0,  1, 1, 32'h11,       0);
        add(1, 2, 32'h22,       1, 7, 32'h77, 0, 0, 7, 0,   1, 0, 1, 0,  1, 2, 32'h22,       0);
        add(1, 3, 32'h33,       1, 7, 32'h77, 0, 0, 7, 0,   1, 0, 1, 0,  1, 3, 32'h33,       0);
        add(1, 4, 32'h44,       1, 7, 32'h77, 0, 0, 7, 0,   0, 1, 1, 0,  1, 7, 32'h77,       0);
        add(1, 4, 32'h44,       1, 8, 32'h88, 0, 0, 7, 0,   1, 0, 1, 0,  1, 4, 32'h44,       0);
        add(0, 0, 0,            1, 8, 32'h88, 0, 0, 7, 0,   0, 1, 0, 0,  1, 8, 32'h88,       0);
        add(1, 0, 32'h55,       0, 0, 0,     0, 0,  7, 0,   1, 0, 0, 0,  0, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,     1, 9,  0, 9,   0, 0, 0, 0,  0, 0, 0,            0);
        add(0, 0, 0,            1, 9, 32'h99, 0, 0, 0, 9,   0, 1, 0, 1,  1, 9, 32'h99,       0);
        add(0, 0, 0,            0, 0, 0,     1, 9,  0, 9,   0, 0, 0, 1,  0, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,     0, 0,  0, 9,   0, 0, 0, 1,  0, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,     1, 9,  0, 9,   0, 0, 0, 1,  0, 0, 0,            1);
        add(0, 0, 0,            0, 0, 0,     0, 0,  0, 9,   0, 0, 0, 1,  0, 0, 0,            1);
        add(0, 0, 0,            1, 0, 32'h1, 0, 0,  0, 9,   0, 1, 0, 1,  0, 0, 0,            1);
        add(0, 0, 0,            0, 0, 0,     0, 0,  0, 9,   0, 0, 0, 1,  0, 0, 0,            1);

        foreach (tbl[i]) begin
            a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
            claim_en = tbl[i].ce; claim_addr = tbl[i].ca;
            rs1_addr = tbl[i].r1; rs2_addr = tbl[i].r2;
            #2;
            chk($sformatf("v%0d_a_ready", i),  32'(a_ready),  32'(tbl[i].xar));
            chk($sformatf("v%0d_b_ready", i),  32'(b_ready),  32'(tbl[i].xbr));
            chk($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].xr1));
            chk($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].xr2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_w_en", i),      32'(w_en),      32'(tbl[i].xwe));
            chk($sformatf("v%0d_claim_err", i), 32'(claim_err), 32'(tbl[i].xerr));
            if (tbl[i].xwe) begin
                chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(tbl[i].xrd));
                chk($sformatf("v%0d_w_in", i),    w_in,          tbl[i].xwi);
            end
        end

        // Asynchronous reset while a write sits in the output stage.
        do_reset();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hCAFEF00D;
        claim_en = 1'b1; claim_addr = 5'd7; rs1_addr = 5'd7;
        @(posedge clk);
        #1;
        idle_inputs();
        rs1_addr = 5'd7;
        chk("midrst_w_en_before", 32'(w_en),     32'd1);
        chk("midrst_busy_before", 32'(rs1_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_w_en",    32'(w_en),     32'd0);
        chk("midrst_rd_addr", 32'(rd_addr),  32'd0);
        chk("midrst_w_in",    w_in,          32'd0);
        chk("midrst_busy",    32'(rs1_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Random traffic; ungranted requests are held stable until accepted.
        hold_a = 1'b0;
        hold_b = 1'b0;
        last_claim = 5'd1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 249) begin
                do_reset();
                hold_a = 1'b0;
                hold_b = 1'b0;
            end
            if (!hold_a) begin
                a_valid = ($urandom_range(0, 9) < 6);
                a_addr  = AW'($urandom);
                a_data  = $urandom;
            end
            if (!hold_b) begin
                b_valid = ($urandom_range(0, 9) < 5);
                b_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : last_claim;
                b_data  = $urandom;
            end
            claim_en   = ($urandom_range(0, 5) == 0);
            claim_addr = AW'($urandom);
            if (claim_en) last_claim = claim_addr;
            rs1_addr = ($urandom_range(0, 1) == 0) ? last_claim : AW'($urandom);
            rs2_addr = AW'($urandom);
            model_cycle(ga, gb);
            hold_a = a_valid && !ga;
            hold_b = b_valid && !gb;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers.
  - Port A: the in-order pipeline writeback.
  - Port B: a long-latency unit (mul/div/load).
- Also holds a destination scoreboard so ID can stall on registers still owed by port B.
- Sits between WB / the long-latency unit and the register file write port (w_en, rd_addr, w_in), with busy lookups returned to ID.

Parameters:
- DATA_WIDTH, 32, write data width (matches `DATA_WIDTH).
- ADDR_WIDTH, 5, register address width (matches `REG_FILE_ADDR_WIDTH).
- MAX_WAIT, 3, consecutive cycles port B may be denied before it is forced ahead of port A (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A request accepted this cycle.
- a_addr  in  ADDR_WIDTH  port A destination.
- a_data  in  DATA_WIDTH  port A data.
- b_valid  in  1  port B write request.
- b_ready  out  1  port B request accepted this cycle.
- b_addr  in  ADDR_WIDTH  port B destination.
- b_data  in  DATA_WIDTH  port B data.
- claim_en  in  1  port B op issued; reserve claim_addr.
- claim_addr  in  ADDR_WIDTH  register reserved by port B.
- rs1_addr  in  ADDR_WIDTH  ID lookup address 1.
- rs2_addr  in  ADDR_WIDTH  ID lookup address 2.
- rs1_busy  out  1  rs1_addr owed by port B.
- rs2_busy  out  1  rs2_addr owed by port B.
- claim_err  out  1  sticky: claim made to an already-busy register.
- w_en  out  1  to reg file write enable.
- rd_addr  out  ADDR_WIDTH  to reg file destination.
- w_in  out  DATA_WIDTH  to reg file write data.

Behaviour:
- Reset (async, rst=1): w_en=0, rd_addr=0, w_in=0, busy[all]=0, starve_cnt=0, claim_err=0, out_is_b=0. Reset mid-write drops that write.

Arbitration (combinational ready, same cycle as valid):
- Only one port valid: that port is granted.
- Both valid: A is granted, unless starve_cnt==MAX_WAIT, in which case B is granted.
- Ungranted port: ready=0; it must hold valid/addr/data stable until granted.
- Neither valid: no grant.

starve_cnt (4 bits, updated at each edge):
- b_valid & !b_ready: increment, saturating at MAX_WAIT.
- Otherwise (B granted or B not valid): clear to 0.

Output stage (registered, 1-cycle latency):
- At the grant edge: w_en<=1, rd_addr<=granted addr, w_in<=granted data, out_is_b<=(B granted).
- No grant: w_en<=0; rd_addr/w_in hold their values.
- Granted addr==0: ready=1 (request consumed), but w_en<=0.
- The reg file commits at the edge after the grant, so total grant-to-visible latency is 2 edges.

Scoreboard (busy bit per register; bit 0 is never set):
- Set: claim_en & claim_addr!=0 sets busy[claim_addr] at the edge.
  - Claim of an already-busy register: busy stays 1 and claim_err<=1 (sticky until reset).
- Clear: busy[rd_addr] clears at the edge where the output stage holds w_en & out_is_b, i.e. the edge the reg file writes it. The bit therefore stays set through the output-stage cycle, so ID never reads a stale value.
- Set and clear on the same address at the same edge: set wins, busy stays 1, and no claim_err.
- rs1_busy = busy[rs1_addr], rs2_busy = busy[rs2_addr]; combinational, 0 for address 0.

Port A writes never touch the scoreboard.

Test Plan:
- Reset then idle -> w_en=0, rs1_busy=rs2_busy=0, claim_err=0. Assert rst mid-write -> w_en drops to 0 immediately (asynchronous).
- A only: a_valid, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle w_en=1, rd_addr=5, w_in=0xDEADBEEF; following cycle w_en=0.
- Both valid continuously, MAX_WAIT=3 -> A granted 3 cycles, B granted on the 4th; starve_cnt returns to 0, then A granted again.
- claim_en, claim_addr=7 -> rs1_busy=1 for rs1_addr=7. Later B writes reg 7 -> rs1_busy stays 1 through the output-stage cycle and is 0 the cycle after w_en for reg 7. rs1_addr=0 always gives 0.
- B write to reg 9 completes (clear) on the same edge as a new claim of 9 -> busy[9]=1, claim_err=0. Claim 9 again while busy -> claim_err=1 and it stays 1.
- A write to addr 0 -> a_ready=1, w_en stays 0. B write to addr 0 -> b_ready=1, no write, no scoreboard change.
